// File: rtl/irq_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : irq_arbiter_pkg
// Purpose  : Shared types, sizes and helpers for the interrupt arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package irq_arbiter_pkg;

  localparam int MAX_IRQ      = 32;
  localparam int IRQ_ID_WIDTH = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } arb_state_e;

  // Index of the lowest set bit; 0 when the vector is empty (caller checks valid).
  function automatic logic [IRQ_ID_WIDTH-1:0] lowest_set_idx(input logic [MAX_IRQ-1:0] vec);
    logic [IRQ_ID_WIDTH-1:0] idx;
    idx = '0;
    for (int i = MAX_IRQ - 1; i >= 0; i--) begin
      if (vec[i]) idx = i[IRQ_ID_WIDTH-1:0];
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_arbiter_prio_pick.sv
`default_nettype none
// ============================================================================
// Module   : irq_prio_pick
// Purpose  : Combinational winner selection. The pending vector is rotated so
//            that base_i lands on bit 0, the lowest set bit is found, and the
//            offset is added back to base_i modulo NUM_IRQ.
// Revision : 1.0 - initial release
// ============================================================================
module irq_prio_pick
  import irq_arbiter_pkg::*;
#(
  parameter int NUM_IRQ  = 32,
  parameter int ID_WIDTH = IRQ_ID_WIDTH
) (
  input  logic [NUM_IRQ-1:0]  pending_i,
  input  logic [ID_WIDTH-1:0] base_i,
  output logic                valid_o,
  output logic [ID_WIDTH-1:0] id_o
);

  localparam logic [ID_WIDTH:0] NUM_W = (ID_WIDTH + 1)'(NUM_IRQ);

  logic [2*NUM_IRQ-1:0]    dbl_w;
  logic [NUM_IRQ-1:0]      rot_w;
  logic [MAX_IRQ-1:0]      rot_ext_w;
  logic [IRQ_ID_WIDTH-1:0] off_w;
  logic [ID_WIDTH:0]       sum_w;
  logic [ID_WIDTH:0]       wrap_w;

  // Doubling the vector turns a variable shift into a rotate for any NUM_IRQ.
  assign dbl_w     = {pending_i, pending_i} >> base_i;
  assign rot_w     = dbl_w[NUM_IRQ-1:0];
  assign rot_ext_w = MAX_IRQ'(rot_w);
  assign off_w     = lowest_set_idx(rot_ext_w);

  // Both operands are below NUM_IRQ, so one conditional subtract wraps the sum.
  assign sum_w   = {1'b0, off_w[ID_WIDTH-1:0]} + {1'b0, base_i};
  assign wrap_w  = (sum_w >= NUM_W) ? (sum_w - NUM_W) : sum_w;
  assign id_o    = wrap_w[ID_WIDTH-1:0];
  assign valid_o = |pending_i;

endmodule
`default_nettype wire

// File: rtl/irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : irq_arbiter
// Purpose  : Latches edge/level interrupt events into a pending register,
//            picks one winner and holds request + ID until the core acks it.
//            Define IRQ_ARB_RR_EN for round-robin selection; otherwise the
//            lowest pending index always wins.
// Revision : 1.0 - initial release
// ============================================================================
module irq_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int          NUM_IRQ    = 32,
  parameter int          ID_WIDTH   = IRQ_ID_WIDTH,
  parameter logic [31:0] LEVEL_MASK = 32'h0
) (
  input  logic                clk_i,
  input  logic                rst_n,
  input  logic                enable_i,
  input  logic [NUM_IRQ-1:0]  irq_i,
  output logic                irq_req_o,
  output logic [ID_WIDTH-1:0] irq_id_o,
  input  logic                irq_ack_i,
  input  logic [ID_WIDTH-1:0] irq_ack_id_i,
  output logic [NUM_IRQ-1:0]  pending_o,
  output logic                ack_err_o
);

  localparam logic [NUM_IRQ-1:0] LVL = LEVEL_MASK[NUM_IRQ-1:0];

  arb_state_e          state_q, state_d;
  logic [NUM_IRQ-1:0]  irq_q;
  logic [NUM_IRQ-1:0]  pending_q, pending_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic                err_q, err_d;

  logic [NUM_IRQ-1:0]  rise_w;
  logic [NUM_IRQ-1:0]  clr_w;
  logic                ack_hit_w;
  logic [ID_WIDTH-1:0] base_w;
  logic                pick_valid_w;
  logic [ID_WIDTH-1:0] pick_id_w;

`ifdef IRQ_ARB_RR_EN
  logic [ID_WIDTH-1:0] rr_q, rr_d;
  assign base_w = rr_q;
`else
  assign base_w = '0;
`endif

  assign rise_w    = irq_i & ~irq_q;
  assign ack_hit_w = (state_q == REQ) && irq_ack_i && (irq_ack_id_i == id_q);

  // One-hot clear of the acknowledged line.
  always_comb begin
    clr_w = '0;
    if (ack_hit_w) clr_w[id_q] = 1'b1;
  end

  // Level lines follow the input; edge lines hold until acked, a new edge wins over the clear.
  assign pending_d = (LVL & irq_i) | (~LVL & ((pending_q & ~clr_w) | rise_w));

  irq_prio_pick #(
    .NUM_IRQ  (NUM_IRQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .pending_i (pending_q),
    .base_i    (base_w),
    .valid_o   (pick_valid_w),
    .id_o      (pick_id_w)
  );

  // Next-state logic: request launch, ack handling, withdrawal and ack errors.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    err_d   = 1'b0;
`ifdef IRQ_ARB_RR_EN
    rr_d    = rr_q;
`endif
    case (state_q)
      IDLE: begin
        err_d = irq_ack_i;
        if (enable_i && pick_valid_w) begin
          state_d = REQ;
          id_d    = pick_id_w;
        end
      end
      REQ: begin
        if (ack_hit_w) begin
          state_d = IDLE;
`ifdef IRQ_ARB_RR_EN
          rr_d    = (id_q == ID_WIDTH'(NUM_IRQ - 1)) ? '0 : id_q + ID_WIDTH'(1);
`endif
        end else begin
          err_d = irq_ack_i;
          if (!enable_i || !pending_q[id_q]) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pending and input history registers.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      irq_q     <= '0;
      pending_q <= '0;
      id_q      <= '0;
      err_q     <= 1'b0;
`ifdef IRQ_ARB_RR_EN
      rr_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_i;
      pending_q <= pending_d;
      id_q      <= id_d;
      err_q     <= err_d;
`ifdef IRQ_ARB_RR_EN
      rr_q      <= rr_d;
`endif
    end
  end

  assign irq_req_o = (state_q == REQ);
  assign irq_id_o  = id_q;
  assign pending_o = pending_q;
  assign ack_err_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_arbiter
// Purpose  : Self-checking bench for irq_arbiter: directed scenarios plus
//            randomized traffic against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_arbiter;

  localparam int          N   = 32;
  localparam logic [31:0] LVL = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] irq = '0;
  logic        ack = 1'b0;
  logic [4:0]  ack_id = '0;
  logic        irq_req_o;
  logic [4:0]  irq_id_o;
  logic [31:0] pending_o;
  logic        ack_err_o;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit          m_req;
  int          m_id;
  int          m_rr;
  bit [31:0]   m_pend;
  bit [31:0]   m_prev;
  bit          m_err;

  irq_arbiter #(
    .NUM_IRQ    (N),
    .ID_WIDTH   (5),
    .LEVEL_MASK (LVL)
  ) dut (
    .clk_i        (clk),
    .rst_n        (rst_n),
    .enable_i     (enable),
    .irq_i        (irq),
    .irq_req_o    (irq_req_o),
    .irq_id_o     (irq_id_o),
    .irq_ack_i    (ack),
    .irq_ack_id_i (ack_id),
    .pending_o    (pending_o),
    .ack_err_o    (ack_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_req = 0; m_id = 0; m_rr = 0; m_pend = '0; m_prev = '0; m_err = 0;
  endfunction

  // Winner: first pending line scanning upward from the search base, wrapping.
  function automatic int model_pick();
    int base;
`ifdef IRQ_ARB_RR_EN
    base = m_rr;
`else
    base = 0;
`endif
    for (int k = 0; k < N; k++) begin
      if (m_pend[(base + k) % N]) return (base + k) % N;
    end
    return 0;
  endfunction

  // One clock of the reference behaviour, using the inputs held across the edge.
  function automatic void model_clock();
    bit [31:0] np;
    bit        hit;
    hit = m_req && ack && (int'(ack_id) == m_id);
    for (int i = 0; i < N; i++) begin
      if (LVL[i]) np[i] = irq[i];
      else        np[i] = (m_pend[i] && !(hit && i == m_id)) || (irq[i] && !m_prev[i]);
    end
    if (!m_req) begin
      if (enable && m_pend != 0) begin
        m_req = 1;
        m_id  = model_pick();
      end
    end else if (hit) begin
      m_req = 0;
      m_rr  = (m_id + 1) % N;
    end else if (!enable || !m_pend[m_id]) begin
      m_req = 0;
    end
    m_err  = ack && !hit;
    m_pend = np;
    m_prev = irq;
  endfunction

  task automatic step();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    chk("m_req", {31'b0, irq_req_o}, {31'b0, m_req});
    if (m_req) chk("m_id", {27'b0, irq_id_o}, m_id);
    chk("m_pend", pending_o, m_pend);
    chk("m_err", {31'b0, ack_err_o}, {31'b0, m_err});
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req", {31'b0, irq_req_o}, 32'd0);
    chk("rst_id", {27'b0, irq_id_o}, 32'd0);
    chk("rst_pend", pending_o, 32'd0);
    chk("rst_err", {31'b0, ack_err_o}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_req();
    int cnt;
    cnt = 0;
    while (!irq_req_o && cnt < 20) begin
      step();
      cnt++;
    end
    if (!irq_req_o) chk("wait_req_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_ack(input logic [4:0] id);
    ack = 1'b1;
    ack_id = id;
    step();
    ack = 1'b0;
  endtask

  initial begin
    int exp_seq[4];
    model_reset();
    #3;
    chk("init_req", {31'b0, irq_req_o}, 32'd0);
    chk("init_pend", pending_o, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;

    // 1: single edge, latency and ack clear
    for (int c = 0; c < 8; c++) step();
    irq[3] = 1'b1;
    step();
    chk("t1_pend", {31'b0, pending_o[3]}, 32'd1);
    chk("t1_req_early", {31'b0, irq_req_o}, 32'd0);
    step();
    chk("t1_req", {31'b0, irq_req_o}, 32'd1);
    chk("t1_id", {27'b0, irq_id_o}, 32'd3);
    do_ack(5'd3);
    chk("t1_req_clr", {31'b0, irq_req_o}, 32'd0);
    chk("t1_pend_clr", {31'b0, pending_o[3]}, 32'd0);
    irq = '0;
    step();

    // 2: simultaneous edges, lower ID first, next one two cycles after ack
    irq[5] = 1'b1; irq[20] = 1'b1;
    step(); step();
    chk("t2_id_a", {27'b0, irq_id_o}, 32'd5);
    do_ack(5'd5);
    chk("t2_gap", {31'b0, irq_req_o}, 32'd0);
    step();
    chk("t2_req_b", {31'b0, irq_req_o}, 32'd1);
    chk("t2_id_b", {27'b0, irq_id_o}, 32'd20);
    do_ack(5'd20);
    irq = '0;
    step();

    // 4: mismatched ack
    irq[3] = 1'b1;
    step(); step();
    chk("t4_id", {27'b0, irq_id_o}, 32'd3);
    do_ack(5'd7);
    chk("t4_err", {31'b0, ack_err_o}, 32'd1);
    chk("t4_req", {31'b0, irq_req_o}, 32'd1);
    chk("t4_id_hold", {27'b0, irq_id_o}, 32'd3);
    chk("t4_pend", {31'b0, pending_o[3]}, 32'd1);
    step();
    chk("t4_err_pulse", {31'b0, ack_err_o}, 32'd0);
    do_ack(5'd3);
    irq = '0;
    step();

    // 6: new edge in the ack-clear cycle, then reset mid-request
    irq[3] = 1'b1;
    step(); step();
    irq[3] = 1'b0;
    step();
    ack = 1'b1; ack_id = 5'd3; irq[3] = 1'b1;
    step();
    ack = 1'b0;
    chk("t6_req_drop", {31'b0, irq_req_o}, 32'd0);
    chk("t6_pend_keep", {31'b0, pending_o[3]}, 32'd1);
    step();
    chk("t6_rereq", {31'b0, irq_req_o}, 32'd1);
    chk("t6_id", {27'b0, irq_id_o}, 32'd3);
    irq = '0;
    apply_reset();

    // 5: level line, enable gating and withdrawal
    enable = 1'b0;
    irq[4] = 1'b1;
    step(); step(); step();
    chk("t5_no_req", {31'b0, irq_req_o}, 32'd0);
    chk("t5_pend", {31'b0, pending_o[4]}, 32'd1);
    enable = 1'b1;
    step();
    chk("t5_req", {31'b0, irq_req_o}, 32'd1);
    chk("t5_id", {27'b0, irq_id_o}, 32'd4);
    irq[4] = 1'b0;
    step(); step();
    chk("t5_withdrawn", {31'b0, irq_req_o}, 32'd0);
    chk("t5_no_err", {31'b0, ack_err_o}, 32'd0);

    // 3: lines 1 and 2 re-pending on every ack
    apply_reset();
`ifdef IRQ_ARB_RR_EN
    exp_seq = '{1, 2, 1, 2};
`else
    exp_seq = '{1, 1, 1, 1};
`endif
    irq[1] = 1'b1; irq[2] = 1'b1;
    step();
    irq = '0;
    for (int r = 0; r < 4; r++) begin
      logic [4:0] got_id;
      wait_req();
      got_id = irq_id_o;
      chk("t3_seq", {27'b0, got_id}, exp_seq[r]);
      ack = 1'b1; ack_id = got_id; irq[got_id] = 1'b1;
      step();
      ack = 1'b0;
      irq = '0;
    end
    step();

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      int r;
      int b;
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 1) == 0) begin
        b = $urandom_range(0, 31);
        irq[b] = ~irq[b];
      end
      ack = 1'b0;
      r = $urandom_range(0, 9);
      if (irq_req_o && r < 4) begin
        ack = 1'b1; ack_id = irq_id_o;
      end else if (r == 4 || r == 5) begin
        ack = 1'b1; ack_id = 5'($urandom_range(0, 31));
      end
      if (c == 300) apply_reset();
      step();
    end
    ack = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
